// File: rtl/memory_responder_if.sv
// Memory request/response bundle between the core (master) and memory_responder (slave).
// memory_error exists only when MEMORY_RESPONDER_ERROR_EN is defined.
interface memory_responder_if;
    logic        memory_enable;
    logic        memory_command;
    logic [31:0] read_memory_address;
    logic [31:0] write_memory_address;
    logic [31:0] write_memory_data;
    logic [31:0] write_memory_mask;
    logic        memory_ready;
    logic        memory_valid;
    logic [31:0] read_memory_data;
`ifdef MEMORY_RESPONDER_ERROR_EN
    logic        memory_error;

    modport master (
        output memory_enable, memory_command, read_memory_address,
               write_memory_address, write_memory_data, write_memory_mask,
        input  memory_ready, memory_valid, read_memory_data, memory_error
    );
    modport slave (
        input  memory_enable, memory_command, read_memory_address,
               write_memory_address, write_memory_data, write_memory_mask,
        output memory_ready, memory_valid, read_memory_data, memory_error
    );
`else
    modport master (
        output memory_enable, memory_command, read_memory_address,
               write_memory_address, write_memory_data, write_memory_mask,
        input  memory_ready, memory_valid, read_memory_data
    );
    modport slave (
        input  memory_enable, memory_command, read_memory_address,
               write_memory_address, write_memory_data, write_memory_mask,
        output memory_ready, memory_valid, read_memory_data
    );
`endif
endinterface

// File: rtl/memory_responder.sv
// Single-request memory slave with fixed completion latency over a word-addressed RAM.
// Optional MEMORY_RESPONDER_ERROR_EN flags out-of-range addresses instead of wrapping.
module memory_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned LATENCY     = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic               clk,
    input  logic               reset,
    memory_responder_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        RESET_WAIT = 2'd0,
        IDLE       = 2'd1,
        WAIT       = 2'd2
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        ready_q;
    logic        valid_q;
    logic [31:0] rdata_q;
    logic        cmd_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] mask_q;
`ifdef MEMORY_RESPONDER_ERROR_EN
    logic        err_q;
`endif

    logic [31:0] mem_q [DEPTH_WORDS];

    logic          accept_s;
    logic          complete_s;
    logic          op_cmd_s;
    logic [31:0]   op_addr_s;
    logic [31:0]   op_wdata_s;
    logic [31:0]   op_mask_s;
    logic [AW-1:0] idx_s;
    logic          oor_s;
    logic [31:0]   old_s;
    logic [31:0]   merged_s;
    logic          write_en_s;
    logic          unused_s;

    // With LATENCY=1 the operation completes on the accepting edge, so it uses the live request.
    always_comb begin
        accept_s   = bus.memory_enable && (state_q == IDLE);
        op_cmd_s   = cmd_q;
        op_addr_s  = addr_q;
        op_wdata_s = wdata_q;
        op_mask_s  = mask_q;
        complete_s = 1'b0;
        if (LATENCY == 32'd1) begin
            op_cmd_s   = bus.memory_command;
            op_addr_s  = bus.memory_command ? bus.write_memory_address : bus.read_memory_address;
            op_wdata_s = bus.write_memory_data;
            op_mask_s  = bus.write_memory_mask;
            complete_s = accept_s;
        end else begin
            complete_s = (state_q == WAIT) && (cnt_q == 4'd1);
        end
        idx_s    = op_addr_s[AW+1:2];
`ifdef MEMORY_RESPONDER_ERROR_EN
        oor_s    = |op_addr_s[31:AW+2];
`else
        oor_s    = 1'b0;
`endif
        old_s      = mem_q[idx_s];
        merged_s   = (old_s & ~op_mask_s) | (op_wdata_s & op_mask_s);
        write_en_s = complete_s && op_cmd_s && !oor_s && !reset;
        unused_s   = ^{op_addr_s[1:0], op_addr_s[31:AW+2]};
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (write_en_s) begin
            mem_q[idx_s] <= merged_s;
        end
    end

    // Request FSM with latency down-counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET_WAIT;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= 32'd0;
            cmd_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            mask_q  <= 32'd0;
`ifdef MEMORY_RESPONDER_ERROR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
`ifdef MEMORY_RESPONDER_ERROR_EN
            err_q   <= 1'b0;
`endif
            case (state_q)
                RESET_WAIT: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                IDLE: begin
                    if (accept_s) begin
                        cmd_q   <= bus.memory_command;
                        addr_q  <= bus.memory_command ? bus.write_memory_address
                                                      : bus.read_memory_address;
                        wdata_q <= bus.write_memory_data;
                        mask_q  <= bus.write_memory_mask;
                        if (LATENCY != 32'd1) begin
                            state_q <= WAIT;
                            ready_q <= 1'b0;
                            cnt_q   <= 4'(LATENCY - 32'd1);
                        end else begin
                            state_q <= IDLE;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q   <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= RESET_WAIT;
                    ready_q <= 1'b0;
                    cnt_q   <= 4'd0;
                end
            endcase
            if (complete_s) begin
                valid_q <= 1'b1;
`ifdef MEMORY_RESPONDER_ERROR_EN
                err_q   <= oor_s;
`endif
                if (!op_cmd_s) begin
                    rdata_q <= oor_s ? 32'd0 : old_s;
                end
            end
        end
    end

    assign bus.memory_ready     = ready_q;
    assign bus.memory_valid     = valid_q;
    assign bus.read_memory_data = rdata_q;
`ifdef MEMORY_RESPONDER_ERROR_EN
    assign bus.memory_error     = err_q;
`endif

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: three instances (LATENCY=1, LATENCY=3, DEPTH_WORDS=16).
module tb_memory_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        en1, en3, en16;
    logic        cmd;
    logic [31:0] addr, wdata, wmask;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    memory_responder_if if1 ();
    memory_responder_if if3 ();
    memory_responder_if if16 ();

    assign if1.memory_enable         = en1;
    assign if1.memory_command        = cmd;
    assign if1.read_memory_address   = addr;
    assign if1.write_memory_address  = addr;
    assign if1.write_memory_data     = wdata;
    assign if1.write_memory_mask     = wmask;
    assign if3.memory_enable         = en3;
    assign if3.memory_command        = cmd;
    assign if3.read_memory_address   = addr;
    assign if3.write_memory_address  = addr;
    assign if3.write_memory_data     = wdata;
    assign if3.write_memory_mask     = wmask;
    assign if16.memory_enable        = en16;
    assign if16.memory_command       = cmd;
    assign if16.read_memory_address  = addr;
    assign if16.write_memory_address = addr;
    assign if16.write_memory_data    = wdata;
    assign if16.write_memory_mask    = wmask;

    memory_responder #(.DEPTH_WORDS(64), .LATENCY(1)) u_l1  (.clk(clk), .reset(reset), .bus(if1.slave));
    memory_responder #(.DEPTH_WORDS(64), .LATENCY(3)) u_l3  (.clk(clk), .reset(reset), .bus(if3.slave));
    memory_responder #(.DEPTH_WORDS(16), .LATENCY(1)) u_d16 (.clk(clk), .reset(reset), .bus(if16.slave));

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic c, input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
        cmd   = c;
        addr  = a;
        wdata = d;
        wmask = m;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        en1 = 1'b0; en3 = 1'b0; en16 = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_value("rst_ready_l1",  32'(if1.memory_ready),  32'd0);
        check_value("rst_valid_l1",  32'(if1.memory_valid),  32'd0);
        check_value("rst_rdata_l1",  if1.read_memory_data,   32'd0);
        check_value("rst_ready_l3",  32'(if3.memory_ready),  32'd0);
        check_value("rst_valid_d16", 32'(if16.memory_valid), 32'd0);
`ifdef MEMORY_RESPONDER_ERROR_EN
        check_value("rst_err_d16",   32'(if16.memory_error), 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);
        check_value("post_ready_l1", 32'(if1.memory_ready), 32'd1);
        check_value("post_valid_l1", 32'(if1.memory_valid), 32'd0);
        check_value("post_ready_l3", 32'(if3.memory_ready), 32'd1);
        @(negedge clk);
        check_value("idle_valid_l1", 32'(if1.memory_valid), 32'd0);
        check_value("idle_ready_l1", 32'(if1.memory_ready), 32'd1);

        // LATENCY=1: one request per cycle
        en1 = 1'b1;
        drive(1'b1, 32'h10, 32'hDEADBEEF, 32'hFFFFFFFF);
        @(negedge clk);
        check_value("l1_w10_valid", 32'(if1.memory_valid), 32'd1);
        check_value("l1_w10_ready", 32'(if1.memory_ready), 32'd1);
        drive(1'b0, 32'h10, 32'h0, 32'h0);
        @(negedge clk);
        check_value("l1_r10_valid", 32'(if1.memory_valid), 32'd1);
        check_value("l1_r10_data",  if1.read_memory_data,  32'hDEADBEEF);
        drive(1'b1, 32'h30, 32'h0BADF00D, 32'hFFFFFFFF);
        @(negedge clk);
        check_value("l1_w30_rdata_held", if1.read_memory_data, 32'hDEADBEEF);
        drive(1'b1, 32'h20, 32'hDEADBEEF, 32'hFFFFFFFF);
        @(negedge clk);
        drive(1'b1, 32'h20, 32'h12345678, 32'h0000FFFF);
        @(negedge clk);
        check_value("l1_mw20_valid", 32'(if1.memory_valid), 32'd1);
        drive(1'b0, 32'h20, 32'h0, 32'h0);
        @(negedge clk);
        check_value("l1_r20_data", if1.read_memory_data, 32'hDEAD5678);
        drive(1'b0, 32'h22, 32'h0, 32'h0);
        @(negedge clk);
        check_value("l1_r22_data", if1.read_memory_data, 32'hDEAD5678);
        drive(1'b0, 32'h30, 32'h0, 32'h0);
        @(negedge clk);
        check_value("l1_r30_data",  if1.read_memory_data,  32'h0BADF00D);
        check_value("l1_r30_valid", 32'(if1.memory_valid), 32'd1);
        drive(1'b0, 32'h10, 32'h0, 32'h0);
        @(negedge clk);
        check_value("l1_r10b_data", if1.read_memory_data, 32'hDEADBEEF);
        en1 = 1'b0;
        @(negedge clk);
        check_value("l1_drop_valid", 32'(if1.memory_valid), 32'd0);
        check_value("l1_drop_rdata", if1.read_memory_data,  32'hDEADBEEF);

        // DEPTH_WORDS=16: address 0x40 wraps to word 0, or is flagged when the error feature is on
        en16 = 1'b1;
        drive(1'b1, 32'h00, 32'h5A5A5A5A, 32'hFFFFFFFF);
        @(negedge clk);
        check_value("d16_w00_valid", 32'(if16.memory_valid), 32'd1);
        drive(1'b1, 32'h40, 32'hA5A5A5A5, 32'hFFFFFFFF);
        @(negedge clk);
        check_value("d16_w40_valid", 32'(if16.memory_valid), 32'd1);
`ifdef MEMORY_RESPONDER_ERROR_EN
        check_value("d16_w40_err", 32'(if16.memory_error), 32'd1);
`endif
        drive(1'b0, 32'h00, 32'h0, 32'h0);
        @(negedge clk);
`ifdef MEMORY_RESPONDER_ERROR_EN
        check_value("d16_r00_data", if16.read_memory_data,  32'h5A5A5A5A);
        check_value("d16_r00_err",  32'(if16.memory_error), 32'd0);
`else
        check_value("d16_r00_data", if16.read_memory_data,  32'hA5A5A5A5);
`endif
        drive(1'b0, 32'h40, 32'h0, 32'h0);
        @(negedge clk);
`ifdef MEMORY_RESPONDER_ERROR_EN
        check_value("d16_r40_data", if16.read_memory_data,  32'h00000000);
        check_value("d16_r40_err",  32'(if16.memory_error), 32'd1);
`else
        check_value("d16_r40_data", if16.read_memory_data,  32'hA5A5A5A5);
`endif
        en16 = 1'b0;
        @(negedge clk);
        check_value("d16_idle_valid", 32'(if16.memory_valid), 32'd0);

        // LATENCY=3: enable held high, inputs changed after acceptance
        en3 = 1'b1;
        drive(1'b1, 32'h40, 32'h11111111, 32'hFFFFFFFF);
        @(negedge clk);
        check_value("l3_w_c1_ready", 32'(if3.memory_ready), 32'd0);
        check_value("l3_w_c1_valid", 32'(if3.memory_valid), 32'd0);
        drive(1'b0, 32'h40, 32'h99999999, 32'h00000000);
        @(negedge clk);
        check_value("l3_w_c2_ready", 32'(if3.memory_ready), 32'd0);
        check_value("l3_w_c2_valid", 32'(if3.memory_valid), 32'd0);
        @(negedge clk);
        check_value("l3_w_c3_valid", 32'(if3.memory_valid), 32'd1);
        check_value("l3_w_c3_ready", 32'(if3.memory_ready), 32'd1);
        check_value("l3_w_c3_rdata", if3.read_memory_data,  32'd0);
        @(negedge clk);
        check_value("l3_r_c1_ready", 32'(if3.memory_ready), 32'd0);
        check_value("l3_r_c1_valid", 32'(if3.memory_valid), 32'd0);
        @(negedge clk);
        check_value("l3_r_c2_valid", 32'(if3.memory_valid), 32'd0);
        @(negedge clk);
        check_value("l3_r_c3_valid", 32'(if3.memory_valid), 32'd1);
        check_value("l3_r_c3_data",  if3.read_memory_data,  32'h11111111);
        en3 = 1'b0;
        @(negedge clk);
        check_value("l3_idle_valid", 32'(if3.memory_valid), 32'd0);
        check_value("l3_idle_ready", 32'(if3.memory_ready), 32'd1);

        // LATENCY=3: reset one cycle after a write is accepted discards it
        en3 = 1'b1;
        drive(1'b1, 32'h40, 32'h22222222, 32'hFFFFFFFF);
        @(negedge clk);
        check_value("l3_rw_ready", 32'(if3.memory_ready), 32'd0);
        en3   = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_value("l3_rst_valid", 32'(if3.memory_valid), 32'd0);
        check_value("l3_rst_ready", 32'(if3.memory_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_value("l3_rel_valid", 32'(if3.memory_valid), 32'd0);
        check_value("l3_rel_ready", 32'(if3.memory_ready), 32'd1);
        en3 = 1'b1;
        drive(1'b0, 32'h40, 32'h0, 32'h0);
        @(negedge clk);
        en3 = 1'b0;
        check_value("l3_rd_c1_valid", 32'(if3.memory_valid), 32'd0);
        @(negedge clk);
        check_value("l3_rd_c2_valid", 32'(if3.memory_valid), 32'd0);
        @(negedge clk);
        check_value("l3_rd_c3_valid", 32'(if3.memory_valid), 32'd1);
        check_value("l3_rd_c3_data",  if3.read_memory_data,  32'h11111111);
        @(negedge clk);
        check_value("l3_rd_end_valid", 32'(if3.memory_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
